// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with mul/div capture, move-to/from access and divide stall
// Optional: HILO_DIV_TIMEOUT_EN adds a 6-bit divide-wait timeout counter and sticky div_err output.
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  aluop,
    input  logic [31:0] res_high,
    input  logic [31:0] res_low,
    input  logic        div_done,
    input  logic [1:0]  mt_we,
    input  logic [31:0] mt_data,
    input  logic [1:0]  mf_sel,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
`ifdef HILO_DIV_TIMEOUT_EN
    output logic        div_err,
`endif
    output logic        stall
);

    typedef enum logic {IDLE, DIV_WAIT} state_t;

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

`ifdef HILO_DIV_TIMEOUT_EN
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef HILO_DIV_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef HILO_DIV_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
`ifdef HILO_DIV_TIMEOUT_EN
        cnt_d   = (state_q == IDLE) ? 6'd0 : cnt_q + 6'd1;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mt_we[1]) hi_d = mt_data;
                if (mt_we[0]) lo_d = mt_data;
                // A mul result overrides any same-cycle move-to write.
                if (ex_valid && aluop == OP_MUL) begin
                    hi_d = res_high;
                    lo_d = res_low;
                end else if (ex_valid && aluop == OP_DIV) begin
                    stall   = 1'b1;
                    state_d = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    hi_d    = res_high;
                    lo_d    = res_low;
                    state_d = IDLE;
`ifdef HILO_DIV_TIMEOUT_EN
                end else if (cnt_q == 6'd63) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads see the value about to be written, so hi_d/lo_d are the source.
    always_comb begin
        rd_data = '0;
        if (!stall) begin
            case (mf_sel)
                2'b01:   rd_data = hi_d;
                2'b10:   rd_data = lo_d;
                default: rd_data = '0;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
`ifdef HILO_DIV_TIMEOUT_EN
    assign div_err = err_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - randomized self-checking bench for hilo_unit against a behavioural model
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  aluop;
    logic [31:0] res_high, res_low;
    logic        div_done;
    logic [1:0]  mt_we;
    logic [31:0] mt_data;
    logic [1:0]  mf_sel;
    logic [31:0] rd_data, hi, lo;
    logic        stall;
`ifdef HILO_DIV_TIMEOUT_EN
    logic        div_err;
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    hilo_unit dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .aluop    (aluop),
        .res_high (res_high),
        .res_low  (res_low),
        .div_done (div_done),
        .mt_we    (mt_we),
        .mt_data  (mt_data),
        .mf_sel   (mf_sel),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo),
`ifdef HILO_DIV_TIMEOUT_EN
        .div_err  (div_err),
`endif
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: register contents, whether a divide is outstanding,
    // how many wait cycles it has spent, and the sticky error.
    logic [31:0] m_hi, m_lo;
    bit          m_div;
    int          m_wait;
    bit          m_err;
    logic        last_stall;
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_div = 0; m_wait = 0; m_err = 0;
    endtask

    task automatic cycle(input logic ev, input logic [3:0] op, input logic [31:0] rh,
                         input logic [31:0] rl, input logic dd, input logic [1:0] we,
                         input logic [31:0] md, input logic [1:0] sel);
        logic [31:0] n_hi, n_lo, e_rd;
        bit          n_div, n_err, e_stall;
        int          n_wait;
        @(negedge clk);
        ex_valid = ev; aluop = op; res_high = rh; res_low = rl;
        div_done = dd; mt_we = we; mt_data = md; mf_sel = sel;
        n_hi = m_hi; n_lo = m_lo; n_div = m_div; n_err = m_err; n_wait = 0; e_stall = 0;
        if (!m_div) begin
            if (we[1]) n_hi = md;
            if (we[0]) n_lo = md;
            if (ev && op == 4'd2) begin
                n_hi = rh; n_lo = rl;
            end else if (ev && op == 4'd3) begin
                e_stall = 1; n_div = 1;
            end
        end else if (dd) begin
            n_hi = rh; n_lo = rl; n_div = 0;
        end else if (TIMEOUT && m_wait == 63) begin
            n_div = 0; n_err = 1;
        end else begin
            e_stall = 1; n_wait = m_wait + 1;
        end
        if (e_stall)          e_rd = '0;
        else if (sel == 2'b01) e_rd = n_hi;
        else if (sel == 2'b10) e_rd = n_lo;
        else                  e_rd = '0;
        #1;
        last_stall = stall;
        last_rd    = rd_data;
        check_eq("stall", {31'd0, stall}, {31'd0, e_stall});
        check_eq("rd_data", rd_data, e_rd);
        @(posedge clk);
        #1;
        m_hi = n_hi; m_lo = n_lo; m_div = n_div; m_wait = n_wait; m_err = n_err;
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
`ifdef HILO_DIV_TIMEOUT_EN
        check_eq("div_err", {31'd0, div_err}, {31'd0, m_err});
`endif
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 2'b00);
    endtask

    initial begin
        int          nstall;
        logic [31:0] r, a, b, c;

        rst = 1'b0; ex_valid = 0; aluop = 0; res_high = 0; res_low = 0;
        div_done = 0; mt_we = 0; mt_data = 0; mf_sel = 2'b01;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hi", hi, 32'd0);
        check_eq("reset_lo", lo, 32'd0);
        check_eq("reset_stall", {31'd0, stall}, 32'd0);
        check_eq("reset_rd", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // mul capture, no stall
        cycle(1'b1, 4'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, 2'b00, 32'd0, 2'b00);
        check_eq("mul_stall", {31'd0, last_stall}, 32'd0);
        check_eq("mul_hi", hi, 32'h1);
        check_eq("mul_lo", lo, 32'hFFFF_FFFE);

        // divide: 33 plain wait cycles then div_done
        nstall = 0;
        cycle(1'b1, 4'd3, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 2'b01);
        if (last_stall) nstall++;
        for (int i = 0; i < 33; i++) begin
            cycle(1'b0, 4'd0, 32'h55, 32'h66, 1'b0, 2'b11, 32'h1234, 2'b10);
            if (last_stall) nstall++;
        end
        cycle(1'b0, 4'd0, 32'h3, 32'h7, 1'b1, 2'b00, 32'd0, 2'b00);
        if (last_stall) nstall++;
        check_eq("div_stall_cycles", nstall, 34);
        check_eq("div_hi", hi, 32'h3);
        check_eq("div_lo", lo, 32'h7);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 2'b00, 32'd0, 2'b01);
        check_eq("idle_after_div", {31'd0, last_stall}, 32'd0);

        // move-to bypass on read
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 2'b10, 32'hDEAD_BEEF, 2'b01);
        check_eq("bypass_rd", last_rd, 32'hDEAD_BEEF);
        check_eq("bypass_hi", hi, 32'hDEAD_BEEF);

        // mul capture beats move-to on LO
        cycle(1'b1, 4'd2, 32'hA5A5_0001, 32'h0BAD_F00D, 1'b0, 2'b01, 32'hCAFE_CAFE, 2'b10);
        check_eq("prio_lo", lo, 32'h0BAD_F00D);
        check_eq("prio_rd", last_rd, 32'h0BAD_F00D);

        // asynchronous reset in the middle of a divide
        cycle(1'b1, 4'd3, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 2'b00);
        idle_cycle();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_mid_hi", hi, 32'd0);
        check_eq("rst_mid_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 4'd0, 32'h99, 32'h88, 1'b1, 2'b00, 32'd0, 2'b00);
        check_eq("late_done_hi", hi, 32'd0);
        check_eq("late_done_lo", lo, 32'd0);

`ifdef HILO_DIV_TIMEOUT_EN
        // divide with no completion times out
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 2'b11, 32'h1357_9BDF, 2'b00);
        nstall = 0;
        cycle(1'b1, 4'd3, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 2'b00);
        if (last_stall) nstall++;
        for (int i = 0; i < 100 && last_stall; i++) begin
            idle_cycle();
            if (last_stall) nstall++;
        end
        check_eq("timeout_stall_cycles", nstall, 64);
        check_eq("timeout_err", {31'd0, div_err}, 32'd1);
        check_eq("timeout_hi", hi, 32'h1357_9BDF);
        check_eq("timeout_lo", lo, 32'h1357_9BDF);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom; a = $urandom; b = $urandom; c = $urandom;
            cycle(r[8] | r[9],
                  r[2] ? {2'b00, r[1:0]} : r[7:4],
                  a, b,
                  (r[12:10] == 3'd0),
                  r[15] ? r[14:13] : 2'b00,
                  c,
                  r[17:16]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ex_valid  input  1  EX-stage instruction valid this cycle.
REQ-004 SHALL have port: aluop  input  4  EX-stage ALU opcode (2 = mul, 3 = div).
REQ-005 SHALL have port: res_high  input  32  ALU high result (mul hi / div remainder).
REQ-006 SHALL have port: res_low  input  32  ALU low result (mul lo / div quotient).
REQ-007 SHALL have port: div_done  input  1  ALU divider completion pulse.
REQ-008 SHALL have port: mt_we  input  2  move-to write enables; bit1 = HI, bit0 = LO.
REQ-009 SHALL have port: mt_data  input  32  move-to write data.
REQ-010 SHALL have port: mf_sel  input  2  read select; 01 = HI, 10 = LO, 00/11 = none.
REQ-011 SHALL have port: rd_data  output  32  move-from read data.
REQ-012 SHALL have port: hi  output  32  HI register.
REQ-013 SHALL have port: lo  output  32  LO register.
REQ-014 SHALL have port: stall  output  1  pipeline stall request.
REQ-015 SHALL have port: div_err  output  1  sticky divide-timeout flag; exists only with HILO_DIV_TIMEOUT_EN.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and DIV_WAIT.
REQ-017 IDLE, ex_valid=1 and aluop=2: SHALL load HI<=res_high and LO<=res_low at the next edge, with no stall.
REQ-018 IDLE, ex_valid=1 and aluop=3: SHALL assert stall combinationally in the same cycle and move to DIV_WAIT at the next edge.
REQ-019 DIV_WAIT: SHALL hold stall=1 and HI/LO unchanged until div_done=1.
REQ-020 DIV_WAIT with div_done=1: SHALL load HI<=res_high and LO<=res_low, deassert stall combinationally that cycle, and return to IDLE.
REQ-021 div_done in IDLE SHALL be ignored.
REQ-022 mt_we writes SHALL update the selected register at the next edge, in IDLE only; in DIV_WAIT they SHALL be ignored.
REQ-023 A same-cycle mul/div capture and mt_we to the same register: the capture SHALL win.
REQ-024 rd_data SHALL be combinational: mf_sel=01 gives HI, 10 gives LO, otherwise 0.
REQ-025 rd_data SHALL bypass pending writes: it returns the value that will be written at the next edge whenever a write to the selected register is active that cycle.
REQ-026 While stall=1, rd_data SHALL be 0.
REQ-027 ex_valid=0 SHALL cause no state change other than the DIV_WAIT progression.

Reset
REQ-028 rst=0 SHALL immediately force HI=0, LO=0, FSM=IDLE, stall=0, the timeout counter to 0 and div_err=0, regardless of clk.
REQ-029 A reset during DIV_WAIT SHALL abandon the divide; any div_done after reset release is ignored per REQ-021.

Configuration
REQ-030 Macro HILO_DIV_TIMEOUT_EN defined: SHALL add a 6-bit counter that clears on DIV_WAIT entry and increments each DIV_WAIT cycle.
REQ-031 With the macro defined, reaching 63 without div_done SHALL set div_err=1 (sticky until reset), return the FSM to IDLE, drop stall, and leave HI/LO unchanged.
REQ-032 Macro undefined: there SHALL be no counter and no div_err port, and DIV_WAIT SHALL wait indefinitely.

Verification
REQ-033 mul: ex_valid=1, aluop=2, res_high=0x00000001, res_low=0xFFFFFFFE -> next edge hi=0x1, lo=0xFFFFFFFE; stall never asserted.
REQ-034 div: aluop=3, then div_done after 33 cycles with res_high=0x3, res_low=0x7 -> stall high for exactly 34 cycles; then hi=0x3, lo=0x7, FSM IDLE.
REQ-035 Bypass: mt_we=10, mt_data=0xDEADBEEF, mf_sel=01 in the same cycle -> rd_data=0xDEADBEEF that cycle and hi=0xDEADBEEF after the edge.
REQ-036 Reset mid-divide: rst=0 during DIV_WAIT -> stall=0, hi=lo=0 immediately; a later div_done pulse leaves hi=lo=0.
REQ-037 HILO_DIV_TIMEOUT_EN defined: div issued, no div_done -> stall drops after 64 cycles, div_err=1, hi/lo keep their prior values.
REQ-038 Priority: aluop=2 capture with mt_we=01 in the same cycle -> lo=res_low, not mt_data.
